// File: rtl/itcm_port_arbiter.sv
// itcm_port_arbiter: shares the single-port ITCM SRAM between instruction
// fetch (default owner) and one external requester (debug / system-bus loader).
// Default build: fetch priority, with a starvation counter that forces an
// external grant once it has waited STARVE_LIMIT cycles.
// Optional macro ITCM_ARB_RR_EN: round-robin arbitration using a last_owner
// register; STARVE_LIMIT and the wait counter are not used in that build.
module itcm_port_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned ITCM_AW      = 14,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  cpu_clk,
   input  logic                  cpu_rstn,
   // fetch port
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  instr_read_data_valid,
   output logic [31:0]           instr_read_data,
   // external port
   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [ADDR_WIDTH-1:0] ext_addr,
   input  logic [31:0]           ext_wdata,
   input  logic [3:0]            ext_be,
   output logic                  ext_gnt,
   output logic                  ext_rvalid,
   output logic [31:0]           ext_rdata,
   // SRAM port
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic [ITCM_AW-1:0]    mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_be,
   input  logic [31:0]           mem_rdata
);

   localparam logic [0:0] OWNER_FETCH = 1'b0;
   localparam logic [0:0] OWNER_EXT   = 1'b1;

   logic grant_ext;
   logic instr_valid_q;
   logic ext_rvalid_q;
   logic ext_is_read_q;

   // Byte-address bits outside the word index are ignored (the ITCM aliases).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[ADDR_WIDTH-1:ITCM_AW+2], if_addr[1:0],
                               ext_addr[ADDR_WIDTH-1:ITCM_AW+2], ext_addr[1:0]};

`ifdef ITCM_ARB_RR_EN
   logic [0:0] last_owner;

   // Contended slot goes to whoever did not own the previous issued slot.
   always_comb begin
      grant_ext = ext_req && (!if_req || (last_owner == OWNER_FETCH));
   end

   // Track the owner of the most recent issued slot; idle slots leave it alone.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         last_owner <= OWNER_FETCH;
      end else if (grant_ext) begin
         last_owner <= OWNER_EXT;
      end else if (if_req) begin
         last_owner <= OWNER_FETCH;
      end
   end

   logic unused_starve;
   assign unused_starve = ^{STARVE_LIMIT[0], OWNER_EXT};
`else
   localparam logic [7:0] STARVE_LIMIT_8 = 8'(STARVE_LIMIT);

   logic [7:0] wait_cnt;

   // Fetch wins unless idle or the external request has waited long enough.
   always_comb begin
      grant_ext = ext_req && (!if_req || (wait_cnt >= STARVE_LIMIT_8));
   end

   // Cycles the pending external request has been refused, saturating.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         wait_cnt <= '0;
      end else if (grant_ext || !ext_req) begin
         wait_cnt <= '0;
      end else if (wait_cnt != 8'hFF) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   logic unused_owner;
   assign unused_owner = ^{OWNER_FETCH, OWNER_EXT};
`endif

   assign ext_gnt = grant_ext;

   // Request phase: steer the selected requester onto the SRAM port.
   always_comb begin
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (grant_ext) begin
         mem_cs    = 1'b1;
         mem_we    = ext_we;
         mem_addr  = ext_addr[ITCM_AW+1:2];
         mem_wdata = ext_wdata;
         mem_be    = ext_be;
      end else if (if_req) begin
         mem_cs    = 1'b1;
         mem_we    = 1'b0;
         mem_addr  = if_addr[ITCM_AW+1:2];
         mem_be    = 4'hF;
      end
   end

   // Data phase: remember who owns the SRAM output in the next cycle.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         instr_valid_q <= 1'b0;
         ext_rvalid_q  <= 1'b0;
         ext_is_read_q <= 1'b0;
      end else begin
         instr_valid_q <= if_req && !grant_ext;
         ext_rvalid_q  <= grant_ext;
         ext_is_read_q <= grant_ext && !ext_we;
      end
   end

   // Data routing: each return bus reads zero unless it owns the data phase.
   always_comb begin
      instr_read_data = instr_valid_q ? mem_rdata : '0;
      ext_rdata       = (ext_rvalid_q && ext_is_read_q) ? mem_rdata : '0;
   end

   assign instr_read_data_valid = instr_valid_q;
   assign ext_rvalid            = ext_rvalid_q;

endmodule

// File: tb/tb_itcm_port_arbiter.sv
// tb_itcm_port_arbiter: directed test of itcm_port_arbiter with a behavioural
// 1-cycle-latency SRAM. Inputs change just after posedge; combinational
// outputs are checked at negedge, registered outputs 1 ns after posedge.
module tb_itcm_port_arbiter;

   localparam int unsigned AW    = 32;
   localparam int unsigned IAW   = 14;
   localparam int unsigned SLIM  = 4;

   logic            cpu_clk;
   logic            cpu_rstn;
   logic            if_req;
   logic [AW-1:0]   if_addr;
   logic            instr_read_data_valid;
   logic [31:0]     instr_read_data;
   logic            ext_req;
   logic            ext_we;
   logic [AW-1:0]   ext_addr;
   logic [31:0]     ext_wdata;
   logic [3:0]      ext_be;
   logic            ext_gnt;
   logic            ext_rvalid;
   logic [31:0]     ext_rdata;
   logic            mem_cs;
   logic            mem_we;
   logic [IAW-1:0]  mem_addr;
   logic [31:0]     mem_wdata;
   logic [3:0]      mem_be;
   logic [31:0]     mem_rdata;

   logic [31:0]     sram [0:(1<<IAW)-1];

   int n_checks = 0;
   int n_fail   = 0;

   itcm_port_arbiter #(
      .ADDR_WIDTH   (AW),
      .ITCM_AW      (IAW),
      .STARVE_LIMIT (SLIM)
   ) dut (
      .cpu_clk               (cpu_clk),
      .cpu_rstn              (cpu_rstn),
      .if_req                (if_req),
      .if_addr               (if_addr),
      .instr_read_data_valid (instr_read_data_valid),
      .instr_read_data       (instr_read_data),
      .ext_req               (ext_req),
      .ext_we                (ext_we),
      .ext_addr              (ext_addr),
      .ext_wdata             (ext_wdata),
      .ext_be                (ext_be),
      .ext_gnt               (ext_gnt),
      .ext_rvalid            (ext_rvalid),
      .ext_rdata             (ext_rdata),
      .mem_cs                (mem_cs),
      .mem_we                (mem_we),
      .mem_addr              (mem_addr),
      .mem_wdata             (mem_wdata),
      .mem_be                (mem_be),
      .mem_rdata             (mem_rdata)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   // Behavioural single-port SRAM, read data one cycle after chip select.
   always @(posedge cpu_clk) begin
      if (mem_cs) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic er, input logic ew,
                        input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] eb);
      if_req    = ir;
      if_addr   = ia;
      ext_req   = er;
      ext_we    = ew;
      ext_addr  = ea;
      ext_wdata = ed;
      ext_be    = eb;
   endtask

   task automatic to_post();
      @(posedge cpu_clk);
      #1;
   endtask

`ifndef ITCM_ARB_RR_EN
   // Fetch streams from 0x200 while ext reads eaddr; grant expected on the 5th cycle.
   task automatic run_starve(input logic [31:0] eaddr, input logic [31:0] exp_data);
      for (int k = 0; k <= int'(SLIM); k++) begin
         drive(1'b1, 32'h200 + 32'(4*k), 1'b1, 1'b0, eaddr, 32'h0, 4'h0);
         @(negedge cpu_clk);
         check_val("starve_gnt", {31'b0, ext_gnt}, {31'b0, k == int'(SLIM)});
         to_post();
         check_val("starve_ivalid", {31'b0, instr_read_data_valid}, {31'b0, k != int'(SLIM)});
         check_val("starve_rvalid", {31'b0, ext_rvalid}, {31'b0, k == int'(SLIM)});
         check_val("starve_rdata", ext_rdata, (k == int'(SLIM)) ? exp_data : 32'h0);
         check_val("starve_idata", instr_read_data,
                   (k == int'(SLIM)) ? 32'h0 : (32'hC0DE0080 + 32'(k)));
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask
`endif

   initial begin
      logic [31:0] fa [4];
      logic [31:0] fd [4];
      fa = '{32'h0, 32'h4, 32'h8, 32'h0001_000C};
      fd = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};

      for (int i = 0; i < (1 << IAW); i++) sram[i] = 32'hC0DE0000 | 32'(i);
      sram[32'h30] = 32'h11223344;
      mem_rdata = 32'h0;
      cpu_rstn  = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

      repeat (2) to_post();
      check_val("rst_ivalid", {31'b0, instr_read_data_valid}, 32'h0);
      check_val("rst_rvalid", {31'b0, ext_rvalid}, 32'h0);
      check_val("rst_idata",  instr_read_data, 32'h0);
      check_val("rst_rdata",  ext_rdata, 32'h0);
      cpu_rstn = 1'b1;

      // Back-to-back fetch, last address aliases onto word 3.
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, fa[k], 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
         @(negedge cpu_clk);
         check_val("fetch_gnt",  {31'b0, ext_gnt}, 32'h0);
         check_val("fetch_cs",   {31'b0, mem_cs}, 32'h1);
         check_val("fetch_addr", 32'(mem_addr), 32'(k));
         check_val("fetch_be",   {28'b0, mem_be}, 32'hF);
         to_post();
         check_val("fetch_valid", {31'b0, instr_read_data_valid}, 32'h1);
         check_val("fetch_data",  instr_read_data, fd[k]);
      end

      // Idle slot.
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge cpu_clk);
      check_val("idle_cs", {31'b0, mem_cs}, 32'h0);
      to_post();
      check_val("idle_valid", {31'b0, instr_read_data_valid}, 32'h0);

      // Ext write then fetch of the same word next cycle.
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
      @(negedge cpu_clk);
      check_val("wr_gnt",   {31'b0, ext_gnt}, 32'h1);
      check_val("wr_we",    {31'b0, mem_we}, 32'h1);
      check_val("wr_addr",  32'(mem_addr), 32'h8);
      check_val("wr_wdata", mem_wdata, 32'hDEADBEEF);
      to_post();
      check_val("wr_rvalid", {31'b0, ext_rvalid}, 32'h1);
      check_val("wr_rdata0", ext_rdata, 32'h0);
      drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      to_post();
      check_val("raw_fetch", instr_read_data, 32'hDEADBEEF);

      // Byte-enable write, then ext read-back.
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hC0, 32'h0000AAAA, 4'b0011);
      @(negedge cpu_clk);
      check_val("be_mem_be", {28'b0, mem_be}, 32'h3);
      to_post();
      check_val("be_rdata0", ext_rdata, 32'h0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hC0, 32'h0, 4'h0);
      to_post();
      check_val("be_rvalid", {31'b0, ext_rvalid}, 32'h1);
      check_val("be_rdata",  ext_rdata, 32'h1122AAAA);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      to_post();
      check_val("rvalid_drop", {31'b0, ext_rvalid}, 32'h0);

`ifndef ITCM_ARB_RR_EN
      // Starvation limit, twice back to back (counter restarts after grant).
      run_starve(32'h100, 32'hC0DE0040);
      run_starve(32'h104, 32'hC0DE0041);

      // Request withdrawn after two refused cycles clears the wait count.
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
         @(negedge cpu_clk);
         check_val("drop_gnt", {31'b0, ext_gnt}, 32'h0);
         to_post();
      end
      drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      to_post();
      run_starve(32'h108, 32'hC0DE0042);
`endif

      // Reset while a granted ext read is entering its data phase.
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
      @(negedge cpu_clk);
      check_val("rstmid_gnt", {31'b0, ext_gnt}, 32'h1);
      cpu_rstn = 1'b0;
      to_post();
      check_val("rstmid_rvalid", {31'b0, ext_rvalid}, 32'h0);
      check_val("rstmid_ivalid", {31'b0, instr_read_data_valid}, 32'h0);
      check_val("rstmid_rdata",  ext_rdata, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge cpu_clk);
      cpu_rstn = 1'b1;
      to_post();
      check_val("rstrel_rvalid", {31'b0, ext_rvalid}, 32'h0);

`ifndef ITCM_ARB_RR_EN
      run_starve(32'h10C, 32'hC0DE0043);
`else
      // Round-robin: both requesting, ext wins first after reset, then alternates.
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 32'h200 + 32'(4*k), 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
         @(negedge cpu_clk);
         check_val("rr_gnt", {31'b0, ext_gnt}, {31'b0, (k % 2) == 0});
         to_post();
         check_val("rr_ivalid", {31'b0, instr_read_data_valid}, {31'b0, (k % 2) == 1});
         check_val("rr_rvalid", {31'b0, ext_rvalid}, {31'b0, (k % 2) == 0});
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
`endif

      to_post();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
